// File: rtl/ecc_pmul_ctrl_pkg.sv
// ============================================================================
// Module  : ecc_pmul_pkg
// Brief   : Shared types and constants for the P-256 point-multiplier
//           sequencer (state encoding, result geometry, default limits).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_pmul_pkg;

  localparam int WORDS  = 8;               // 32-bit words per coordinate
  localparam int WORD_W = 32;
  localparam int ADDR_W = 3;
  localparam int RES_W  = WORDS * WORD_W;

  localparam logic [31:0] DEF_TIMEOUT     = 32'd8_000_000;
  localparam int          DEF_ACK_CYCLES  = 16;
  localparam int          DEF_SRST_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_RECOVER  = 3'd4
  } state_t;

  // One-hot mask bit for a result word index.
  function automatic logic [WORDS-1:0] word_bit(input logic [ADDR_W-1:0] addr);
    logic [WORDS-1:0] b;
    b       = '0;
    b[addr] = 1'b1;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_pmul_ctrl_if.sv
// ============================================================================
// Module  : ecc_pmul_ctrl_if
// Brief   : Handshake and result-write bus between the sequencer (master)
//           and the curve_mul_256 core (slave).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ecc_pmul_ctrl_if;
  import ecc_pmul_pkg::*;

  logic              ena;
  logic              srst_n;
  logic              rdy;
  logic              rx_wren;
  logic              ry_wren;
  logic [ADDR_W-1:0] rx_addr;
  logic [ADDR_W-1:0] ry_addr;
  logic [WORD_W-1:0] rx_dout;
  logic [WORD_W-1:0] ry_dout;

  modport master (
    output ena, srst_n,
    input  rdy, rx_wren, ry_wren, rx_addr, ry_addr, rx_dout, ry_dout
  );

  modport slave (
    input  ena, srst_n,
    output rdy, rx_wren, ry_wren, rx_addr, ry_addr, rx_dout, ry_dout
  );

endinterface

`default_nettype wire

// File: rtl/ecc_pmul_ctrl.sv
// ============================================================================
// Module  : ecc_pmul_ctrl
// Brief   : Sequencer for the P-256 point multiplier: start pulse, rdy
//           handshake tracking, result capture, run-cycle count, scope
//           trigger, and timeout recovery via a core soft-reset pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_pmul_ctrl
  import ecc_pmul_pkg::*;
#(
  parameter int          pCNT_WIDTH   = 32,
  parameter logic [31:0] pTIMEOUT     = DEF_TIMEOUT,
  parameter int          pACK_CYCLES  = DEF_ACK_CYCLES,
  parameter int          pSRST_CYCLES = DEF_SRST_CYCLES
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_timeout_o,
  output logic                       err_incomplete_o,
  output logic                       trigger_o,
  output logic [pCNT_WIDTH-1:0]      cycles_o,
  output logic [RES_W-1:0]           rx_o,
  output logic [RES_W-1:0]           ry_o,
  ecc_pmul_ctrl_if.master            core
);

  localparam int                    WAIT_W    = 16;
  localparam logic [WAIT_W-1:0]     ACK_LAST  = WAIT_W'(pACK_CYCLES - 1);
  localparam logic [WAIT_W-1:0]     SRST_LAST = WAIT_W'(pSRST_CYCLES - 1);
  localparam logic [pCNT_WIDTH-1:0] TIMEOUT_C = pCNT_WIDTH'(pTIMEOUT);

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [pCNT_WIDTH-1:0]   cycles_q, cycles_d;
  logic                    done_q, done_d;
  logic                    err_to_q, err_to_d;
  logic                    err_inc_q, err_inc_d;
  logic [WORDS-1:0]        rx_mask_q, ry_mask_q;
  logic [WORDS-1:0]        rx_mask_d, ry_mask_d;
  logic [RES_W-1:0]        rx_q, ry_q;
  logic                    clr_run;
  logic                    rx_wr, ry_wr;
  logic                    cyc_sat;

  // Writes only count while the core is running; the rdy-rising cycle is
  // still RUN, so its writes are folded into the completeness check.
  always_comb begin
    rx_wr     = core.rx_wren && (state_q == S_RUN);
    ry_wr     = core.ry_wren && (state_q == S_RUN);
    rx_mask_d = rx_mask_q | (rx_wr ? word_bit(core.rx_addr) : '0);
    ry_mask_d = ry_mask_q | (ry_wr ? word_bit(core.ry_addr) : '0);
    cyc_sat   = &cycles_q;
  end

  // State and status register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_inc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cycles_q   <= cycles_d;
      done_q     <= done_d;
      err_to_q   <= err_to_d;
      err_inc_q  <= err_inc_d;
    end
  end

  // Next-state, counters and sticky flags.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    cycles_d   = cycles_q;
    done_d     = done_q;
    err_to_d   = err_to_q;
    err_inc_d  = err_inc_q;
    clr_run    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_START;
          clr_run   = 1'b1;
          done_d    = 1'b0;
          err_to_d  = 1'b0;
          err_inc_d = 1'b0;
          cycles_d  = '0;
        end
      end
      S_START: begin
        state_d    = S_WAIT_ACK;
        wait_cnt_d = '0;
      end
      S_WAIT_ACK: begin
        if (!core.rdy) begin
          state_d = S_RUN;
        end else if (wait_cnt_q == ACK_LAST) begin
          state_d    = S_RECOVER;
          err_to_d   = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        // Completion has priority over the timeout in the same cycle.
        if (core.rdy) begin
          state_d = S_IDLE;
          if ((&rx_mask_d) && (&ry_mask_d)) done_d    = 1'b1;
          else                              err_inc_d = 1'b1;
          if (!cyc_sat) cycles_d = cycles_q + 1'b1;
        end else if (cycles_q == TIMEOUT_C) begin
          state_d    = S_RECOVER;
          err_to_d   = 1'b1;
          wait_cnt_d = '0;
        end else if (!cyc_sat) begin
          cycles_d = cycles_q + 1'b1;
        end
      end
      S_RECOVER: begin
        if (wait_cnt_q == SRST_LAST) state_d    = S_IDLE;
        else                         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // X-coordinate capture: data lands in its word slot, mask tracks coverage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q      <= '0;
      rx_mask_q <= '0;
    end else if (clr_run) begin
      rx_mask_q <= '0;
    end else if (rx_wr) begin
      rx_q[WORD_W*core.rx_addr +: WORD_W] <= core.rx_dout;
      rx_mask_q                           <= rx_mask_d;
    end
  end

  // Y-coordinate capture, independent of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ry_q      <= '0;
      ry_mask_q <= '0;
    end else if (clr_run) begin
      ry_mask_q <= '0;
    end else if (ry_wr) begin
      ry_q[WORD_W*core.ry_addr +: WORD_W] <= core.ry_dout;
      ry_mask_q                           <= ry_mask_d;
    end
  end

  // All control outputs decode directly from registered state.
  assign busy_o           = (state_q != S_IDLE);
  assign trigger_o        = (state_q == S_RUN);
  assign core.ena         = (state_q == S_START);
  assign core.srst_n      = (state_q != S_RECOVER);
  assign done_o           = done_q;
  assign err_timeout_o    = err_to_q;
  assign err_incomplete_o = err_inc_q;
  assign cycles_o         = cycles_q;
  assign rx_o             = rx_q;
  assign ry_o             = ry_q;

endmodule

`default_nettype wire

// File: tb/tb_ecc_pmul_ctrl.sv
// ============================================================================
// Module  : tb_ecc_pmul_ctrl
// Brief   : Directed self-checking bench for ecc_pmul_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ecc_pmul_ctrl;

  logic clk;
  logic rst_n;
  logic start_i, start_to;

  logic         busy_o, done_o, err_to_o, err_inc_o, trigger_o;
  logic [31:0]  cycles_o;
  logic [255:0] rx_o, ry_o;

  logic         t_busy, t_done, t_err_to, t_err_inc, t_trig;
  logic [31:0]  t_cycles;
  logic [255:0] t_rx, t_ry;

  int checks = 0;
  int errors = 0;
  int ena_total = 0;
  int trig_total = 0;

  // Observations recorded by core_run for the calling test.
  logic obs_busy_e, obs_ena_e, obs_done_e, obs_trig_r, obs_trig_r1;
  logic [31:0] obs_cycles_e;

  ecc_pmul_ctrl_if cif ();
  ecc_pmul_ctrl_if cif_to ();

  ecc_pmul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_to_o),
    .err_incomplete_o(err_inc_o), .trigger_o(trigger_o),
    .cycles_o(cycles_o), .rx_o(rx_o), .ry_o(ry_o), .core(cif)
  );

  ecc_pmul_ctrl #(.pTIMEOUT(32'd100)) dut_to (
    .clk(clk), .rst_n(rst_n), .start_i(start_to),
    .busy_o(t_busy), .done_o(t_done), .err_timeout_o(t_err_to),
    .err_incomplete_o(t_err_inc), .trigger_o(t_trig),
    .cycles_o(t_cycles), .rx_o(t_rx), .ry_o(t_ry), .core(cif_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cif.ena)   ena_total  <= ena_total + 1;
    if (trigger_o) trig_total <= trig_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] exp_words(input logic [31:0] base);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = base + 32'(i);
    return v;
  endfunction

  // Core model: drop rdy 2 cycles after ena, write 8 words per coordinate,
  // raise rdy after len RUN cycles. skip_ry < 0 writes all ry words.
  task automatic core_run(input int len, input logic [31:0] rxb, input logic [31:0] ryb,
                          input int skip_ry, input int start_at);
    start_i = 1'b1;
    tick();                           // cycle E: START
    start_i      = 1'b0;
    obs_busy_e   = busy_o;
    obs_ena_e    = cif.ena;
    obs_done_e   = done_o;
    obs_cycles_e = cycles_o;
    tick();                           // E+1
    tick();                           // E+2 = r
    cif.rdy    = 1'b0;
    obs_trig_r = trigger_o;
    for (int k = 1; k <= len; k++) begin
      tick();
      if (k == 1) obs_trig_r1 = trigger_o;
      cif.rx_wren = 1'b0;
      cif.ry_wren = 1'b0;
      start_i     = 1'b0;
      if (k <= 8) begin
        cif.rx_wren = 1'b1;
        cif.rx_addr = 3'(k - 1);
        cif.rx_dout = rxb + 32'(k - 1);
        cif.ry_wren = ((k - 1) != skip_ry);
        cif.ry_addr = 3'(k - 1);
        cif.ry_dout = ryb + 32'(k - 1);
      end
      if (k == start_at) start_i = 1'b1;
      if (k == len) cif.rdy = 1'b1;
    end
    tick();                           // s+1
    cif.rx_wren = 1'b0;
    cif.ry_wren = 1'b0;
    start_i     = 1'b0;
  endtask

  task automatic test_reset();
    if (busy_o !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++;
    if (done_o !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++;
    if (err_to_o !== 1'b0 || err_inc_o !== 1'b0) begin
      errors++; $display("FAIL reset_err: got to=%b inc=%b want 0 0", err_to_o, err_inc_o);
    end
    checks++;
    if (trigger_o !== 1'b0 || cif.ena !== 1'b0) begin
      errors++; $display("FAIL reset_trig_ena: got %b %b want 0 0", trigger_o, cif.ena);
    end
    checks++;
    if (cif.srst_n !== 1'b1)  begin errors++; $display("FAIL reset_srst_n: got %b want 1", cif.srst_n); end
    checks++;
    if (cycles_o !== 32'd0 || rx_o !== '0 || ry_o !== '0) begin
      errors++; $display("FAIL reset_data: got cycles=%0d rx=%h want 0", cycles_o, rx_o);
    end
    checks++;
  endtask

  task automatic test_nominal();
    int trig0;
    trig0 = trig_total;
    core_run(500, 32'h1000_0000, 32'h2000_0000, -1, 0);
    if (obs_busy_e !== 1'b1 || obs_ena_e !== 1'b1) begin
      errors++; $display("FAIL nom_start_latency: got busy=%b ena=%b want 1 1", obs_busy_e, obs_ena_e);
    end
    checks++;
    if (obs_trig_r !== 1'b0 || obs_trig_r1 !== 1'b1) begin
      errors++; $display("FAIL nom_trig_edge: got r=%b r1=%b want 0 1", obs_trig_r, obs_trig_r1);
    end
    checks++;
    if (done_o !== 1'b1 || err_inc_o !== 1'b0 || err_to_o !== 1'b0) begin
      errors++; $display("FAIL nom_flags: got done=%b inc=%b to=%b want 1 0 0", done_o, err_inc_o, err_to_o);
    end
    checks++;
    if (busy_o !== 1'b0 || trigger_o !== 1'b0) begin
      errors++; $display("FAIL nom_end: got busy=%b trig=%b want 0 0", busy_o, trigger_o);
    end
    checks++;
    if (cycles_o !== 32'd500) begin errors++; $display("FAIL nom_cycles: got %0d want 500", cycles_o); end
    checks++;
    if (rx_o[31:0] !== 32'h1000_0000) begin errors++; $display("FAIL nom_rx0: got %h want 10000000", rx_o[31:0]); end
    checks++;
    if (ry_o[255:224] !== 32'h2000_0007) begin errors++; $display("FAIL nom_ry7: got %h want 20000007", ry_o[255:224]); end
    checks++;
    if (rx_o !== exp_words(32'h1000_0000) || ry_o !== exp_words(32'h2000_0000)) begin
      errors++; $display("FAIL nom_words: got rx=%h ry=%h", rx_o, ry_o);
    end
    checks++;
    if (trig_total - trig0 !== 500) begin errors++; $display("FAIL nom_trig_len: got %0d want 500", trig_total - trig0); end
    checks++;
  endtask

  task automatic test_incomplete();
    core_run(300, 32'h1100_0000, 32'h2100_0000, 5, 0);
    if (obs_done_e !== 1'b0 || obs_cycles_e !== 32'd0) begin
      errors++; $display("FAIL inc_clear_on_start: got done=%b cycles=%0d want 0 0", obs_done_e, obs_cycles_e);
    end
    checks++;
    if (err_inc_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL inc_flags: got inc=%b done=%b want 1 0", err_inc_o, done_o);
    end
    checks++;
    if (ry_o[191:160] !== 32'h2000_0005 || ry_o[223:192] !== 32'h2100_0006) begin
      errors++; $display("FAIL inc_ry_hold: got w5=%h w6=%h want 20000005 21000006", ry_o[191:160], ry_o[223:192]);
    end
    checks++;
    if (rx_o !== exp_words(32'h1100_0000)) begin errors++; $display("FAIL inc_rx: got %h", rx_o); end
    checks++;
  endtask

  task automatic test_no_ack();
    int lowcnt;
    start_i = 1'b1;
    tick();                           // E
    start_i = 1'b0;
    for (int i = 0; i < 16; i++) tick();   // E+16, last WAIT_ACK cycle
    if (err_to_o !== 1'b0 || cif.srst_n !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL noack_early: got to=%b srst_n=%b busy=%b want 0 1 1", err_to_o, cif.srst_n, busy_o);
    end
    checks++;
    tick();                           // E+17
    if (err_to_o !== 1'b1) begin errors++; $display("FAIL noack_err: got %b want 1", err_to_o); end
    checks++;
    lowcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (cif.srst_n === 1'b0) lowcnt++;
      if (i == 4 && busy_o !== 1'b0) begin
        errors++; $display("FAIL noack_busy: got %b want 0", busy_o);
      end
      if (i == 4) checks++;
      tick();
    end
    if (lowcnt !== 4) begin errors++; $display("FAIL noack_srst_len: got %0d want 4", lowcnt); end
    checks++;
  endtask

  task automatic test_run_timeout();
    start_to = 1'b1;
    tick();                           // E
    start_to = 1'b0;
    tick();                           // r
    cif_to.rdy = 1'b0;
    for (int k = 1; k <= 101; k++) tick();  // cycles_o reaches 100
    if (t_cycles !== 32'd100 || t_trig !== 1'b1) begin
      errors++; $display("FAIL to_reach: got cycles=%0d trig=%b want 100 1", t_cycles, t_trig);
    end
    checks++;
    tick();                           // RECOVER
    if (t_err_to !== 1'b1 || cif_to.srst_n !== 1'b0 || t_trig !== 1'b0 || t_cycles !== 32'd100) begin
      errors++; $display("FAIL to_recover: got err=%b srst_n=%b trig=%b cycles=%0d want 1 0 0 100",
                         t_err_to, cif_to.srst_n, t_trig, t_cycles);
    end
    checks++;
    for (int i = 0; i < 3; i++) tick();
    if (t_busy !== 1'b1 || cif_to.srst_n !== 1'b0) begin
      errors++; $display("FAIL to_recover_len: got busy=%b srst_n=%b want 1 0", t_busy, cif_to.srst_n);
    end
    checks++;
    tick();
    if (t_busy !== 1'b0 || cif_to.srst_n !== 1'b1 || t_done !== 1'b0) begin
      errors++; $display("FAIL to_idle: got busy=%b srst_n=%b done=%b want 0 1 0", t_busy, cif_to.srst_n, t_done);
    end
    checks++;
    cif_to.rdy = 1'b1;
  endtask

  task automatic test_back_to_back();
    int ena0;
    ena0 = ena_total;
    core_run(200, 32'h3000_0000, 32'h4000_0000, -1, 50);
    tick();
    if (ena_total - ena0 !== 1) begin errors++; $display("FAIL b2b_ena_count: got %0d want 1", ena_total - ena0); end
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || cycles_o !== 32'd200) begin
      errors++; $display("FAIL b2b_first: got done=%b busy=%b cycles=%0d want 1 0 200", done_o, busy_o, cycles_o);
    end
    checks++;
    core_run(150, 32'h5000_0000, 32'h6000_0000, -1, 0);
    if (obs_done_e !== 1'b0 || obs_cycles_e !== 32'd0) begin
      errors++; $display("FAIL b2b_clear: got done=%b cycles=%0d want 0 0", obs_done_e, obs_cycles_e);
    end
    checks++;
    if (done_o !== 1'b1 || cycles_o !== 32'd150 || rx_o !== exp_words(32'h5000_0000) ||
        ry_o !== exp_words(32'h6000_0000)) begin
      errors++; $display("FAIL b2b_second: got done=%b cycles=%0d rx0=%h", done_o, cycles_o, rx_o[31:0]);
    end
    checks++;
  endtask

  task automatic test_reset_mid_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    cif.rdy = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      cif.rx_wren = (k <= 8);
      cif.rx_addr = 3'(k - 1);
      cif.rx_dout = 32'h7000_0000;
    end
    rst_n = 1'b0;
    #1;
    if (busy_o !== 1'b0 || trigger_o !== 1'b0 || cycles_o !== 32'd0 || done_o !== 1'b0 ||
        rx_o !== '0 || ry_o !== '0 || cif.srst_n !== 1'b1) begin
      errors++; $display("FAIL rst_mid: got busy=%b trig=%b cycles=%0d done=%b rx0=%h",
                         busy_o, trigger_o, cycles_o, done_o, rx_o[31:0]);
    end
    checks++;
    cif.rdy     = 1'b1;
    cif.rx_wren = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    core_run(64, 32'h8000_0000, 32'h9000_0000, -1, 0);
    if (done_o !== 1'b1 || cycles_o !== 32'd64 || rx_o !== exp_words(32'h8000_0000)) begin
      errors++; $display("FAIL rst_fresh_run: got done=%b cycles=%0d rx0=%h want 1 64 80000000",
                         done_o, cycles_o, rx_o[31:0]);
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b1;
    start_i = 1'b0;
    start_to = 1'b0;
    cif.rdy = 1'b1;  cif.rx_wren = 1'b0; cif.ry_wren = 1'b0;
    cif.rx_addr = '0; cif.ry_addr = '0; cif.rx_dout = '0; cif.ry_dout = '0;
    cif_to.rdy = 1'b1; cif_to.rx_wren = 1'b0; cif_to.ry_wren = 1'b0;
    cif_to.rx_addr = '0; cif_to.ry_addr = '0; cif_to.rx_dout = '0; cif_to.ry_dout = '0;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_nominal();
    tick();
    test_incomplete();
    tick();
    test_no_ack();
    tick();
    test_run_timeout();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ecc_pmul_ctrl.md
# ecc_pmul_ctrl

Sequencer between the host register block and the `curve_mul_256` P-256 point multiplier.
- Turns a host start request into a single-cycle `ena` pulse and tracks the core's `rdy` handshake.
- Captures the eight 32-bit result words of each coordinate into 256-bit result registers.
- Counts run cycles, drives the scope trigger, and detects a hung or incomplete run. A hung core is recovered with a local soft-reset pulse.

## Interface
Parameters:
- `pCNT_WIDTH`, 32: cycle-counter width.
- `pTIMEOUT`, 32'd8_000_000: maximum RUN cycles before abort.
- `pACK_CYCLES`, 16: maximum cycles from `ena` to `rdy` falling.
- `pSRST_CYCLES`, 4: length of the core soft-reset pulse.

Ports:
- `clk`  in  1  single clock for the block and the core.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  one-cycle start request from the register block.
- `busy_o`  out  1  operation in progress.
- `done_o`  out  1  sticky: last run completed cleanly.
- `err_timeout_o`  out  1  sticky: no ack or RUN timeout.
- `err_incomplete_o`  out  1  sticky: `rdy` returned before all 16 words were written.
- `trigger_o`  out  1  high exactly while in RUN.
- `cycles_o`  out  pCNT_WIDTH  RUN-cycle count of the last or current run.
- `core_ena_o`  out  1  start pulse to the core.
- `core_srst_n_o`  out  1  active-low soft reset to the core; the top level ANDs it with `rst_n`.
- `core_rdy_i`  in  1  core idle/ready.
- `core_rx_wren_i`, `core_ry_wren_i`  in  1  result word write strobes.
- `core_rx_addr_i`, `core_ry_addr_i`  in  3  result word index.
- `core_rx_dout_i`, `core_ry_dout_i`  in  32  result word data.
- `rx_o`, `ry_o`  out  256  captured result coordinates.

## Operation
- States: IDLE, START, WAIT_ACK, RUN, RECOVER.
- IDLE:
  - `start_i`=1 → START.
  - On entry to START: clear `done_o`, both error flags, `cycles_o` and both 8-bit write masks.
  - `rx_o`/`ry_o` hold their old values until overwritten.
- START: `core_ena_o`=1 for this one cycle → WAIT_ACK.
- WAIT_ACK:
  - `core_rdy_i`=0 → RUN.
  - Otherwise, after `pACK_CYCLES` cycles in WAIT_ACK: set `err_timeout_o` → RECOVER.
- RUN:
  - `cycles_o` increments each cycle, saturating at all-ones.
  - Each write with `core_rx_wren_i`=1 stores `core_rx_dout_i` into `rx_o[32*addr +: 32]` (addr 0 = least-significant word) and sets mask bit addr. `ry` is handled identically and independently.
  - `core_rdy_i`=1 → IDLE. Set `done_o` if both masks are 8'hFF; otherwise set `err_incomplete_o`.
  - Writes in the same cycle as `rdy` rising are captured and counted in the mask check.
  - `cycles_o` reaching `pTIMEOUT` → set `err_timeout_o` → RECOVER.
- RECOVER: `core_srst_n_o`=0 for `pSRST_CYCLES` cycles → IDLE.
- `busy_o`=1 in every state except IDLE.
- `start_i` is ignored outside IDLE; there is no queueing.

## Timing
- Reset values: all outputs 0 except `core_srst_n_o`=1. State = IDLE.
- `rst_n` asserted mid-run returns the block to IDLE asynchronously and clears all results and flags.
- `start_i` in cycle t → `busy_o`=1 and `core_ena_o`=1 in cycle t+1 (registered outputs).
- `rdy` falling at cycle r → RUN and `trigger_o`=1 from r+1.
- `rdy` rising at cycle s → `done_o`/error flag, `busy_o`=0 and `trigger_o`=0 at s+1.
- `cycles_o` = number of RUN cycles, i.e. s−r.
- Timeout at `cycles_o`==`pTIMEOUT` → RECOVER next cycle. `busy_o` drops `pSRST_CYCLES`+1 cycles later.
- A duplicate write to the same addr overwrites the data; the mask stays set.

## Structure
- Shared package `ecc_pmul_pkg`: state enum, word count (8), word width (32), default timeout constants.
- Single module; no sub-module. The capture logic is two identical always blocks, one per coordinate.

## Test plan
- Nominal run: core model drops `rdy` 2 cycles after `ena`, writes rx words 0..7 = 32'h1000_0000+i and ry words = 32'h2000_0000+i, then raises `rdy` after 500 cycles → `done_o`=1, `cycles_o`=500, `rx_o[31:0]`=32'h1000_0000, `ry_o[255:224]`=32'h2000_0007, `trigger_o` high for exactly 500 cycles.
- Incomplete: same run but ry word 5 never written → `err_incomplete_o`=1, `done_o`=0.
- No ack: `rdy` held high → `err_timeout_o`=1 after 16 cycles; `core_srst_n_o` low for 4 cycles; `busy_o`=0 after that.
- Run timeout with `pTIMEOUT`=100 and `rdy` held low → `err_timeout_o`=1, `cycles_o`=100, RECOVER pulse observed.
- `start_i` pulsed during RUN → ignored: one `ena` pulse total, result unchanged. Start after `done_o` → flags clear, new run proceeds.
- `rst_n` asserted mid-RUN → all outputs return to reset values immediately; a fresh start then completes normally.
